// File: rtl/board_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : board_renderer
//  Description : Rasterises an 8x8 puzzle board snapshot into VGA pixel writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_renderer #(
  parameter int CELL_PX  = 12,
  parameter int ORIGIN_X = 32,
  parameter int ORIGIN_Y = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] game_grid,
  input  logic [63:0] block1,
  input  logic [63:0] block2,
  input  logic [63:0] block3,
  input  logic [2:0]  block1_x,
  input  logic [2:0]  block1_y,
  input  logic [2:0]  block2_x,
  input  logic [2:0]  block2_y,
  input  logic [2:0]  block3_x,
  input  logic [2:0]  block3_y,
  input  logic [1:0]  active_sel,
  input  logic        game_over,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done
);
  localparam int                c_PX_W    = $clog2(CELL_PX);
  localparam logic [c_PX_W-1:0] c_PX_LAST = c_PX_W'(CELL_PX - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  logic [63:0]         r_grid;
  logic [2:0][63:0]    r_blk;
  logic [2:0][2:0]     r_bx, r_by;
  logic [1:0]          r_sel;
  logic                r_go;
  logic [2:0]          r_row, r_col, w_row_nx, w_col_nx;
  logic [c_PX_W-1:0]   r_py, r_px, w_py_nx, w_px_nx;
  logic                w_capture;
  logic [2:0]          w_cov;
  logic                w_cell, w_act, w_oth;
  logic [2:0]          w_pix_colour;
  logic [7:0]          w_pix_x, w_x_nx;
  logic [6:0]          w_pix_y, w_y_nx;
  logic [2:0]          w_colour_nx;
  logic                w_plot_nx, w_busy_nx, w_done_nx;

  function automatic logic covers(input logic [63:0] mask, input logic [2:0] ox,
                                  input logic [2:0] oy, input logic [2:0] r,
                                  input logic [2:0] c);
    logic [2:0] dr, dc;
    dr = r - oy;
    dc = c - ox;
    return (r >= oy) && (c >= ox) && mask[{dr, dc}];
  endfunction

  // Pixel colour for the current scan position, evaluated from the snapshot only
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_cov[i] = covers(r_blk[i], r_bx[i], r_by[i], r_row, r_col);
    end
    w_cell = r_grid[{r_row, r_col}];
    w_act  = (r_sel == 2'd1 && w_cov[0]) || (r_sel == 2'd2 && w_cov[1]) ||
             (r_sel == 2'd3 && w_cov[2]);
    w_oth  = (r_sel != 2'd1 && w_cov[0]) || (r_sel != 2'd2 && w_cov[1]) ||
             (r_sel != 2'd3 && w_cov[2]);
    if (r_px == '0 || r_py == '0) w_pix_colour = 3'b111;
    else if (r_go)                w_pix_colour = w_cell ? 3'b100 : 3'b000;
    else if (w_act)               w_pix_colour = w_cell ? 3'b100 : 3'b110;
    else if (w_oth)               w_pix_colour = 3'b011;
    else if (w_cell)              w_pix_colour = 3'b010;
    else                          w_pix_colour = 3'b000;
    w_pix_x = 8'(ORIGIN_X) + 8'(r_col) * 8'(CELL_PX) + 8'(r_px);
    w_pix_y = 7'(ORIGIN_Y) + 7'(r_row) * 7'(CELL_PX) + 7'(r_py);
  end

  always_comb begin
    w_state_nx  = r_state;
    w_row_nx    = r_row;
    w_col_nx    = r_col;
    w_py_nx     = r_py;
    w_px_nx     = r_px;
    w_capture   = 1'b0;
    w_plot_nx   = 1'b0;
    w_busy_nx   = 1'b0;
    w_done_nx   = 1'b0;
    w_x_nx      = vga_x;
    w_y_nx      = vga_y;
    w_colour_nx = vga_colour;
    case (r_state)
      S_IDLE: begin
        w_row_nx = '0;
        w_col_nx = '0;
        w_py_nx  = '0;
        w_px_nx  = '0;
        if (start) begin
          w_capture  = 1'b1;
          w_state_nx = S_DRAW;
        end
      end
      S_DRAW: begin
        w_plot_nx   = 1'b1;
        w_busy_nx   = 1'b1;
        w_x_nx      = w_pix_x;
        w_y_nx      = w_pix_y;
        w_colour_nx = w_pix_colour;
        // Raster order: px fastest, then col, then py, then row
        if (r_px != c_PX_LAST) begin
          w_px_nx = r_px + 1'b1;
        end else begin
          w_px_nx = '0;
          if (r_col != 3'd7) begin
            w_col_nx = r_col + 3'd1;
          end else begin
            w_col_nx = '0;
            if (r_py != c_PX_LAST) begin
              w_py_nx = r_py + 1'b1;
            end else begin
              w_py_nx = '0;
              if (r_row != 3'd7) begin
                w_row_nx = r_row + 3'd1;
              end else begin
                w_row_nx   = '0;
                w_state_nx = S_DONE;
              end
            end
          end
        end
      end
      S_DONE: begin
        w_done_nx  = 1'b1;
        w_busy_nx  = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grid     <= '0;
      r_blk      <= '0;
      r_bx       <= '0;
      r_by       <= '0;
      r_sel      <= '0;
      r_go       <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_py       <= '0;
      r_px       <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_grid <= game_grid;
        r_blk  <= {block3, block2, block1};
        r_bx   <= {block3_x, block2_x, block1_x};
        r_by   <= {block3_y, block2_y, block1_y};
        r_sel  <= active_sel;
        r_go   <= game_over;
      end
      r_row      <= w_row_nx;
      r_col      <= w_col_nx;
      r_py       <= w_py_nx;
      r_px       <= w_px_nx;
      vga_x      <= w_x_nx;
      vga_y      <= w_y_nx;
      vga_colour <= w_colour_nx;
      vga_plot   <= w_plot_nx;
      busy       <= w_busy_nx;
      done       <= w_done_nx;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_board_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_renderer
//  Description : Self-checking bench for board_renderer with a pixel-index model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_renderer;
  localparam int C     = 12;
  localparam int FRAME = 64 * C * C;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [63:0] game_grid, block1, block2, block3;
  logic [2:0]  block1_x, block1_y, block2_x, block2_y, block3_x, block3_y;
  logic [1:0]  active_sel;
  logic        game_over;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy, done;

  always #5 clk = ~clk;

  board_renderer dut (
    .clk(clk), .reset(reset), .start(start), .game_grid(game_grid),
    .block1(block1), .block2(block2), .block3(block3),
    .block1_x(block1_x), .block1_y(block1_y), .block2_x(block2_x), .block2_y(block2_y),
    .block3_x(block3_x), .block3_y(block3_y), .active_sel(active_sel),
    .game_over(game_over), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  int          n_assert = 0, n_fail = 0;
  logic [63:0] m_grid;
  logic [63:0] m_blk [3];
  logic [2:0]  m_x [3], m_y [3];
  logic [1:0]  m_sel;
  logic        m_go;
  logic [2:0]  fb [160][120];
  bit          mon_on = 1'b0;
  int          mon_cyc, pix_cnt, n111, n000, done_cnt, done_at;
  int          first_x, first_y, first_c, last_x, last_y, last_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pixel k of the frame, derived by decomposing the linear pixel index
  function automatic logic [2:0] model_pixel(input int k, output int mx, output int my);
    int  row, py, col, px, rem;
    logic g, act, oth;
    logic cov [3];
    row = k / (C * C * 8);
    rem = k % (C * C * 8);
    py  = rem / (C * 8);
    rem = rem % (C * 8);
    col = rem / C;
    px  = rem % C;
    mx  = 32 + col * C + px;
    my  = 12 + row * C + py;
    g   = m_grid[row * 8 + col];
    for (int n = 0; n < 3; n++) begin
      cov[n] = 1'b0;
      if (row >= int'(m_y[n]) && col >= int'(m_x[n]))
        cov[n] = m_blk[n][(row - int'(m_y[n])) * 8 + (col - int'(m_x[n]))];
    end
    if (px == 0 || py == 0) return 3'b111;
    if (m_go) return g ? 3'b100 : 3'b000;
    act = (m_sel != 2'd0) && cov[int'(m_sel) - 1];
    oth = 1'b0;
    for (int n = 0; n < 3; n++) if (cov[n] && (n + 1) != int'(m_sel)) oth = 1'b1;
    if (act) return g ? 3'b100 : 3'b110;
    if (oth) return 3'b011;
    if (g) return 3'b010;
    return 3'b000;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      int ex, ey;
      logic [2:0] ec;
      logic exp_plot;
      mon_cyc++;
      exp_plot = (mon_cyc >= 1 && mon_cyc <= FRAME);
      check("plot", 32'(vga_plot), 32'(exp_plot));
      check("busy", 32'(busy), 32'(mon_cyc >= 1 && mon_cyc <= FRAME + 1));
      check("done", 32'(done), 32'(mon_cyc == FRAME + 1));
      if (exp_plot && vga_plot) begin
        ec = model_pixel(mon_cyc - 1, ex, ey);
        check("pix_x", 32'(vga_x), 32'(ex));
        check("pix_y", 32'(vga_y), 32'(ey));
        check("pix_colour", 32'(vga_colour), 32'(ec));
      end
      if (vga_plot) begin
        pix_cnt++;
        if (vga_x < 8'd160 && vga_y < 7'd120) fb[vga_x][vga_y] = vga_colour;
        if (vga_colour == 3'b111) n111++;
        if (vga_colour == 3'b000) n000++;
        if (pix_cnt == 1) begin
          first_x = int'(vga_x); first_y = int'(vga_y); first_c = int'(vga_colour);
        end
        last_x = int'(vga_x); last_y = int'(vga_y); last_c = int'(vga_colour);
      end
      if (done) begin
        done_cnt++;
        done_at = mon_cyc;
      end
      if (mon_cyc >= FRAME + 2) mon_on = 1'b0;
    end
  end

  task automatic start_frame();
    @(negedge clk); #1;
    m_grid = game_grid;
    m_blk[0] = block1; m_blk[1] = block2; m_blk[2] = block3;
    m_x[0] = block1_x; m_x[1] = block2_x; m_x[2] = block3_x;
    m_y[0] = block1_y; m_y[1] = block2_y; m_y[2] = block3_y;
    m_sel = active_sel; m_go = game_over;
    pix_cnt = 0; n111 = 0; n000 = 0; done_cnt = 0; done_at = -1;
    mon_cyc = -1; mon_on = 1'b1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    int g = 0;
    while (mon_on && mon_cyc < k && g < 20000) begin
      @(negedge clk); #1;
      g++;
    end
    check("reach_cycle", 32'(mon_cyc >= k), 32'd1);
  endtask

  task automatic wait_frame();
    int g = 0;
    while (mon_on && g < 20000) begin
      @(negedge clk); #1;
      g++;
    end
    if (mon_on) begin
      check("frame_timeout", 32'd1, 32'd0);
      mon_on = 1'b0;
    end
    check("frame_pixels", 32'(pix_cnt), 32'(FRAME));
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_at), 32'(FRAME + 1));
  endtask

  task automatic clear_inputs();
    game_grid = '0; block1 = '0; block2 = '0; block3 = '0;
    block1_x = '0; block1_y = '0; block2_x = '0; block2_y = '0;
    block3_x = '0; block3_y = '0; active_sel = '0; game_over = 1'b0;
  endtask

  initial begin
    int junk;
    reset = 1'b1; start = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_xyc", {13'd0, vga_x, vga_y, vga_colour}, 32'd0);
    #1 reset = 1'b0;

    // Empty board
    start_frame(); wait_frame();
    check("first_x", 32'(first_x), 32'd32);
    check("first_y", 32'(first_y), 32'd12);
    check("first_c", 32'(first_c), 32'd7);
    check("last_x", 32'(last_x), 32'd127);
    check("last_y", 32'(last_y), 32'd107);
    check("last_c", 32'(last_c), 32'd0);
    check("count_000", 32'(n000), 32'd7744);
    check("count_111", 32'(n111), 32'd1472);

    // Single occupied cell (0,0)
    game_grid = 64'h1;
    start_frame(); wait_frame();
    check("t2_in_lo", 32'(fb[33][13]), 32'd2);
    check("t2_in_hi", 32'(fb[43][23]), 32'd2);
    check("t2_border", 32'(fb[44][13]), 32'd7);
    check("t2_right", 32'(fb[45][14]), 32'd0);
    check("t2_below", 32'(fb[33][25]), 32'd0);

    // Active piece, then collision with grid bit 26
    game_grid = '0; block1 = 64'h3; block1_x = 3'd2; block1_y = 3'd3; active_sel = 2'd1;
    start_frame(); wait_frame();
    check("t3_c32", 32'(fb[57][49]), 32'd6);
    check("t3_c33", 32'(fb[69][59]), 32'd6);
    check("t3_c34", 32'(fb[81][49]), 32'd0);
    game_grid = 64'h1 << 26;
    start_frame(); wait_frame();
    check("t3_coll", 32'(fb[57][49]), 32'd4);
    check("t3_nocoll", 32'(fb[69][49]), 32'd6);

    // Game over hides pieces
    clear_inputs();
    game_over = 1'b1; game_grid = 64'h1 << 63; block2 = 64'h1;
    start_frame(); wait_frame();
    check("t4_c77", 32'(fb[117][97]), 32'd4);
    check("t4_c00", 32'(fb[33][13]), 32'd0);

    // Overlapping inactive pieces; start and grid flip mid-frame are ignored
    clear_inputs();
    block2 = 64'h1; block3 = 64'h1;
    start_frame();
    wait_cyc(100);
    start = 1'b1; game_grid = '1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_frame();
    check("t5_overlap", 32'(fb[33][13]), 32'd3);
    check("t5_snapshot", 32'(fb[45][13]), 32'd0);

    // Reset mid-frame
    clear_inputs();
    game_grid = 64'h8100_0000_0000_0081;
    start_frame();
    wait_cyc(500);
    check("t6_pix_before", 32'(pix_cnt), 32'd500);
    mon_on = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_plot", 32'(vga_plot), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    junk = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy || vga_plot) junk++;
    end
    check("t6_quiet", 32'(junk), 32'd0);
    start_frame(); wait_frame();
    check("t6_corner", 32'(fb[117][97]), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
